cdb_arbiter: RTL and testbench

//   Responder end of the common-data-bus require/requireAC handshake. Four result sources
//   (0 ALU, 1 MUL, 2 DIV, 3 load/store) raise require with data+label; block grants one per

---
 rtl/cdb_arbiter_if.sv | 32 +++
 rtl/cdb_arbiter.sv | 76 +++++++
 tb/tb_cdb_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Common-data-bus handshake bundle: four result sources with require/requireAC,
// plus the registered broadcast seen by register file, reservation stations and queues.
interface cdb_arbiter_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4
);
  logic [3:0]         require;
  logic [DATA_W-1:0]  data0;
  logic [DATA_W-1:0]  data1;
  logic [DATA_W-1:0]  data2;
  logic [DATA_W-1:0]  data3;
  logic [LABEL_W-1:0] label0;
  logic [LABEL_W-1:0] label1;
  logic [LABEL_W-1:0] label2;
  logic [LABEL_W-1:0] label3;
  logic [3:0]         requireAC;
  logic               BCEN;
  logic [LABEL_W-1:0] BClabel;
  logic [DATA_W-1:0]  BCdata;

  // Sources and broadcast consumers.
  modport master (
    output require, data0, data1, data2, data3, label0, label1, label2, label3,
    input  requireAC, BCEN, BClabel, BCdata
  );

  // Arbiter.
  modport slave (
    input  require, data0, data1, data2, data3, label0, label1, label2, label3,
    output requireAC, BCEN, BClabel, BCdata
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin responder for the common data bus: grants one source per cycle and
// broadcasts its label/data one cycle later.
module cdb_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4
) (
  input  logic          clk,
  input  logic          nRST,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned N_SRC = 4;

  logic [1:0]         r_ptr;
  logic               r_bcen;
  logic [LABEL_W-1:0] r_bclabel;
  logic [DATA_W-1:0]  r_bcdata;

  logic               w_found;
  logic [1:0]         w_win;
  logic [1:0]         w_idx;
  logic [3:0]         w_grant;
  logic [LABEL_W-1:0] w_label;
  logic [DATA_W-1:0]  w_data;

  // First requester at or after the pointer wins; no grant while in reset.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    w_grant = 4'd0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && bus.require[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (w_found && nRST) begin
      w_grant[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_label = bus.label0;
    w_data  = bus.data0;
    case (w_win)
      2'd0: begin w_label = bus.label0; w_data = bus.data0; end
      2'd1: begin w_label = bus.label1; w_data = bus.data1; end
      2'd2: begin w_label = bus.label2; w_data = bus.data2; end
      default: begin w_label = bus.label3; w_data = bus.data3; end
    endcase
  end

  // Label 0 means "no producer": consumed and pointer advanced, but not announced.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_ptr     <= 2'd0;
      r_bcen    <= 1'b0;
      r_bclabel <= '0;
      r_bcdata  <= '0;
    end else if (w_found) begin
      r_ptr     <= w_win + 2'd1;
      r_bcen    <= (w_label != '0);
      r_bclabel <= w_label;
      r_bcdata  <= w_data;
    end else begin
      r_bcen    <= 1'b0;
      r_bclabel <= '0;
    end
  end

  assign bus.requireAC = w_grant;
  assign bus.BCEN      = r_bcen;
  assign bus.BClabel   = r_bclabel;
  assign bus.BCdata    = r_bcdata;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin order, pointer wrap,
// label-0 suppression and asynchronous reset during a broadcast.
module tb_cdb_arbiter;
  logic clk;
  logic nRST;
  int   n_vec;
  int   n_err;

  cdb_arbiter_if #(.DATA_W(32), .LABEL_W(4)) bus ();

  cdb_arbiter #(.DATA_W(32), .LABEL_W(4)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked 1ns after that.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nRST  = 1'b0;
    bus.require = 4'b1111;
    bus.data0 = 32'h0000_0A00; bus.data1 = 32'h0000_0A01;
    bus.data2 = 32'h0000_0A02; bus.data3 = 32'h0000_0A03;
    bus.label0 = 4'd1; bus.label1 = 4'd2; bus.label2 = 4'd3; bus.label3 = 4'd4;

    // 1: reset with all sources requesting
    edge_step();
    chk("rst_ac",    32'(bus.requireAC), 32'h0);
    chk("rst_bcen",  32'(bus.BCEN),      32'h0);
    chk("rst_label", 32'(bus.BClabel),   32'h0);
    chk("rst_data",  bus.BCdata,         32'h0);
    bus.require = 4'b0000;
    nRST = 1'b1;

    // 2: single request from source 1
    edge_step();
    bus.require = 4'b0010; bus.label1 = 4'd5; bus.data1 = 32'hDEAD_BEEF;
    #1;
    chk("single_ac", 32'(bus.requireAC), 32'h2);
    edge_step();
    bus.require = 4'b0000;
    #1;
    chk("single_bcen",  32'(bus.BCEN),    32'h1);
    chk("single_label", 32'(bus.BClabel), 32'h5);
    chk("single_data",  bus.BCdata,       32'hDEAD_BEEF);
    chk("single_ac_off", 32'(bus.requireAC), 32'h0);
    edge_step();
    chk("single_bcen_off", 32'(bus.BCEN), 32'h0);
    chk("single_data_hold", bus.BCdata, 32'hDEAD_BEEF);

    // Pointer is at 2; pulse reset so round-robin starts from source 0.
    nRST = 1'b0;
    #1;
    nRST = 1'b1;

    // 3: all four requesting with labels 1..4
    bus.label0 = 4'd1; bus.label1 = 4'd2; bus.label2 = 4'd3; bus.label3 = 4'd4;
    bus.data1 = 32'h0000_0A01;
    bus.require = 4'b1111;
    #1;
    chk("rr_ac0", 32'(bus.requireAC), 32'h1);
    edge_step();
    chk("rr_bcen0", 32'(bus.BCEN), 32'h1);
    chk("rr_lab0",  32'(bus.BClabel), 32'h1);
    chk("rr_dat0",  bus.BCdata, 32'h0000_0A00);
    chk("rr_ac1", 32'(bus.requireAC), 32'h2);
    edge_step();
    chk("rr_bcen1", 32'(bus.BCEN), 32'h1);
    chk("rr_lab1",  32'(bus.BClabel), 32'h2);
    chk("rr_ac2", 32'(bus.requireAC), 32'h4);
    edge_step();
    chk("rr_bcen2", 32'(bus.BCEN), 32'h1);
    chk("rr_lab2",  32'(bus.BClabel), 32'h3);
    chk("rr_ac3", 32'(bus.requireAC), 32'h8);
    edge_step();
    bus.require = 4'b0000;
    chk("rr_bcen3", 32'(bus.BCEN), 32'h1);
    chk("rr_lab3",  32'(bus.BClabel), 32'h4);
    chk("rr_dat3",  bus.BCdata, 32'h0000_0A03);
    edge_step();
    chk("rr_bcen_off", 32'(bus.BCEN), 32'h0);
    chk("rr_lab_off",  32'(bus.BClabel), 32'h0);

    // 4: grant 2, then 0101 wraps past absent 3 to 0, then 0100 -> 2
    bus.require = 4'b0100;
    #1;
    chk("ptr_ac2", 32'(bus.requireAC), 32'h4);
    edge_step();
    bus.require = 4'b0101;
    #1;
    chk("ptr_wrap", 32'(bus.requireAC), 32'h1);
    edge_step();
    chk("ptr_wrap_lab", 32'(bus.BClabel), 32'h1);
    bus.require = 4'b0100;
    #1;
    chk("ptr_next", 32'(bus.requireAC), 32'h4);
    edge_step();
    chk("ptr_next_lab", 32'(bus.BClabel), 32'h3);

    // 5: label 0 from source 3 is consumed silently, pointer wraps to 0
    bus.require = 4'b1000; bus.label3 = 4'd0; bus.data3 = 32'h1234_5678;
    #1;
    chk("lab0_ac", 32'(bus.requireAC), 32'h8);
    edge_step();
    bus.require = 4'b0000;
    #1;
    chk("lab0_bcen",  32'(bus.BCEN),    32'h0);
    chk("lab0_label", 32'(bus.BClabel), 32'h0);
    bus.require = 4'b0011;
    #1;
    chk("lab0_ptr0", 32'(bus.requireAC), 32'h1);
    edge_step();
    bus.require = 4'b0000;
    chk("lab0_after_bcen", 32'(bus.BCEN), 32'h1);

    // 6: async reset while a broadcast is on the bus
    edge_step();
    bus.require = 4'b0010; bus.label1 = 4'd7; bus.data1 = 32'hCAFE_F00D;
    edge_step();
    bus.require = 4'b0110; bus.label2 = 4'd9;
    chk("ar_bcen_pre", 32'(bus.BCEN), 32'h1);
    chk("ar_lab_pre",  32'(bus.BClabel), 32'h7);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_bcen",  32'(bus.BCEN),      32'h0);
    chk("ar_label", 32'(bus.BClabel),   32'h0);
    chk("ar_data",  bus.BCdata,         32'h0);
    chk("ar_ac",    32'(bus.requireAC), 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    #1;
    chk("ar_ptr_reset", 32'(bus.requireAC), 32'h2);
    bus.require = 4'b0100;
    #1;
    chk("ar_grant2", 32'(bus.requireAC), 32'h4);
    edge_step();
    bus.require = 4'b0000;
    chk("ar_post_bcen", 32'(bus.BCEN), 32'h1);
    chk("ar_post_lab",  32'(bus.BClabel), 32'h9);

    edge_step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
